// File: rtl/soc_run_ctrl_if.sv
// Handshake bundle for soc_run_ctrl: run-control requests in, domain resets and run status out.
interface soc_run_ctrl_if #(
  parameter int NUM_RST = 4,
  parameter int CNT_W   = 16
);
  logic               start;
  logic               halt_req;
  logic               kick;
  logic [NUM_RST-1:0] rst_o;
  logic               running;
  logic               done;
  logic               timeout;
  logic [CNT_W-1:0]   cycle_cnt;

  modport master (
    output start, halt_req, kick,
    input  rst_o, running, done, timeout, cycle_cnt
  );

  modport slave (
    input  start, halt_req, kick,
    output rst_o, running, done, timeout, cycle_cnt
  );
endinterface

// File: rtl/soc_run_ctrl.sv
// soc_run_ctrl: staggered per-domain reset release, cycle-budgeted run and sticky completion flags.
// Optional progress watchdog is built only when RUN_CTRL_WATCHDOG_EN is defined.
module soc_run_ctrl #(
  parameter int NUM_RST     = 4,
  parameter int HOLD_CYCLES = 10,
  parameter int STAGGER     = 2,
  parameter int RUN_CYCLES  = 50,
  parameter int WDT_CYCLES  = 20,
  parameter int CNT_W       = 16
) (
  input logic           clk,
  input logic           rst,
  soc_run_ctrl_if.slave bus
);
  localparam int IDX_W = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

  typedef enum logic [2:0] {
    S_HOLD,
    S_RELEASE,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_RST-1:0] rst_o_q, rst_o_d;
  logic               running_q, running_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d, cyc_inc;
  logic               wdt_hit;

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign cyc_inc = cyc_q + CNT_W'(1);

`ifdef RUN_CTRL_WATCHDOG_EN
  logic [CNT_W-1:0] wdt_q, wdt_d, wdt_inc;

  assign wdt_inc = bus.kick ? '0 : wdt_q + CNT_W'(1);
  assign wdt_hit = (wdt_inc == CNT_W'(WDT_CYCLES));

  // Held at zero outside RUN, so it is already clear on RUN entry.
  always_comb begin
    wdt_d = wdt_inc;
    if (state_q != S_RUN) wdt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wdt_q <= '0;
    else     wdt_q <= wdt_d;
  end
`else
  logic unused_wdt;
  assign unused_wdt = bus.kick ^ (WDT_CYCLES == 0);
  assign wdt_hit    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_o_d   = rst_o_q;
    running_d = running_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    cyc_d     = cyc_q;
    case (state_q)
      S_HOLD: begin
        cnt_d = cnt_inc;
        if (cnt_inc == CNT_W'(HOLD_CYCLES)) begin
          cnt_d      = '0;
          rst_o_d[0] = 1'b0;
          if (NUM_RST == 1) begin
            state_d   = S_RUN;
            running_d = 1'b1;
          end else begin
            state_d = S_RELEASE;
            idx_d   = IDX_W'(1);
          end
        end
      end
      S_RELEASE: begin
        cnt_d = cnt_inc;
        if (cnt_inc == CNT_W'(STAGGER)) begin
          cnt_d          = '0;
          rst_o_d[idx_q] = 1'b0;
          idx_d          = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUM_RST - 1)) begin
            state_d   = S_RUN;
            running_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        cyc_d = cyc_inc;
        // Normal completion outranks a watchdog expiry on the same edge.
        if ((cyc_inc == CNT_W'(RUN_CYCLES)) || bus.halt_req) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          running_d = 1'b0;
        end else if (wdt_hit) begin
          state_d   = S_TIMEOUT;
          timeout_d = 1'b1;
          running_d = 1'b0;
          rst_o_d   = '1;
        end
      end
      S_DONE, S_TIMEOUT: begin
        if (bus.start) begin
          state_d   = S_HOLD;
          rst_o_d   = '1;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          cyc_d     = '0;
          cnt_d     = '0;
          idx_d     = '0;
        end
      end
      default: begin
        state_d   = S_HOLD;
        rst_o_d   = '1;
        running_d = 1'b0;
        cnt_d     = '0;
        idx_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_o_q   <= '1;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      cyc_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_o_q   <= rst_o_d;
      running_q <= running_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      cyc_q     <= cyc_d;
    end
  end

  assign bus.rst_o     = rst_o_q;
  assign bus.running   = running_q;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;
  assign bus.cycle_cnt = cyc_q;
endmodule

// File: tb/tb_soc_run_ctrl.sv
// Scoreboard bench for soc_run_ctrl: expectations are tagged with the post-reset edge number and
// popped by a monitor that samples the DUT on the falling clock edge.
module tb_soc_run_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  soc_run_ctrl_if #(.NUM_RST(4), .CNT_W(16)) bus ();

  soc_run_ctrl #(
    .NUM_RST(4), .HOLD_CYCLES(10), .STAGGER(2),
    .RUN_CYCLES(50), .WDT_CYCLES(20), .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          phase;
    int          tag;
    string       name;
    logic [3:0]  rst_o;
    logic        running;
    logic        done;
    logic        timeout;
    logic [15:0] cnt;
    bit          chk_cnt;
  } exp_t;

  exp_t sb[$];
  int   edge_n   = 0;
  int   phase    = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Edge k = k-th rising edge with rst low.
  always @(posedge clk or posedge rst) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  always @(negedge clk) begin : monitor
    exp_t x;
    bit   ok;
    while (sb.size() > 0 && sb[0].phase == phase && sb[0].tag <= edge_n) begin
      x = sb.pop_front();
      n_checks++;
      if (x.tag < edge_n) begin
        $display("FAIL %s: not sampled at edge %0d (now edge %0d)", x.name, x.tag, edge_n);
      end else begin
        ok = (bus.rst_o === x.rst_o) && (bus.running === x.running) &&
             (bus.done === x.done) && (bus.timeout === x.timeout) &&
             (!x.chk_cnt || (bus.cycle_cnt === x.cnt));
        if (ok) n_pass++;
        else $display("FAIL %s @edge %0d: got rst_o=%b run=%b done=%b to=%b cnt=%0d, want rst_o=%b run=%b done=%b to=%b cnt=%0d",
                      x.name, edge_n, bus.rst_o, bus.running, bus.done, bus.timeout, bus.cycle_cnt,
                      x.rst_o, x.running, x.done, x.timeout, x.cnt);
      end
    end
  end

  function automatic void expect_at(input int tag, input string name, input logic [3:0] ro,
                                    input logic run, input logic dn, input logic to,
                                    input int cnt, input bit chk_cnt = 1'b1);
    exp_t x;
    x.phase = phase; x.tag = tag; x.name = name; x.rst_o = ro;
    x.running = run; x.done = dn; x.timeout = to; x.cnt = 16'(cnt); x.chk_cnt = chk_cnt;
    sb.push_back(x);
  endfunction

  task automatic step_to(input int e);
    int g = 0;
    while (edge_n < e && g < 4000) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic pulse_halt(input int m);
    step_to(m - 1); bus.halt_req = 1'b1;
    step_to(m);     bus.halt_req = 1'b0;
  endtask

  task automatic pulse_kick(input int m);
    step_to(m - 1); bus.kick = 1'b1;
    step_to(m);     bus.kick = 1'b0;
  endtask

  task automatic pulse_start(input int m);
    step_to(m - 1); bus.start = 1'b1;
    step_to(m);     bus.start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    bus.start = 1'b0; bus.halt_req = 1'b0; bus.kick = 1'b0;
    rst = 1'b1;
    phase++;
    expect_at(0, "reset_vals", 4'b1111, 1'b0, 1'b0, 1'b0, 0);
    repeat (3) @(negedge clk);
    #3 rst = 1'b0;
  endtask

  // Anything still queued after the budget was never presented by the DUT.
  task automatic drain(input int budget);
    exp_t x;
    int k = 0;
    while (sb.size() > 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      n_checks++;
      $display("FAIL %s: never observed, wanted at edge %0d (now edge %0d)", x.name, x.tag, edge_n);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.halt_req = 1'b0; bus.kick = 1'b0;

    // Full sequence with periodic kicks, ignored start/halt, budget+halt collision, re-arm.
    do_reset();
    expect_at(9,  "hold_end",      4'b1111, 0, 0, 0, 0);
    expect_at(10, "rel0",          4'b1110, 0, 0, 0, 0);
    expect_at(12, "rel1",          4'b1100, 0, 0, 0, 0);
    expect_at(14, "rel2",          4'b1000, 0, 0, 0, 0);
    expect_at(15, "pre_run",       4'b1000, 0, 0, 0, 0);
    expect_at(16, "run_entry",     4'b0000, 1, 0, 0, 0);
    expect_at(17, "run_first",     4'b0000, 1, 0, 0, 1);
    expect_at(41, "start_in_run",  4'b0000, 1, 0, 0, 25);
    expect_at(65, "budget_m1",     4'b0000, 1, 0, 0, 49);
    expect_at(66, "budget_done",   4'b0000, 0, 1, 0, 50);
    expect_at(75, "done_frozen",   4'b0000, 0, 1, 0, 50);
    expect_at(80, "start_rearm",   4'b1111, 0, 0, 0, 0);
    expect_at(89, "rearm_hold",    4'b1111, 0, 0, 0, 0);
    expect_at(90, "rearm_rel0",    4'b1110, 0, 0, 0, 0);
    expect_at(96, "rearm_run",     4'b0000, 1, 0, 0, 0);
`ifdef RUN_CTRL_WATCHDOG_EN
    expect_at(115, "wdt_pre",      4'b0000, 1, 0, 0, 19);
    expect_at(116, "wdt_timeout",  4'b1111, 0, 0, 1, 0, 1'b0);
    expect_at(120, "wdt_sticky",   4'b1111, 0, 0, 1, 0, 1'b0);
`else
    expect_at(145, "nokick_m1",    4'b0000, 1, 0, 0, 49);
    expect_at(146, "nokick_done",  4'b0000, 0, 1, 0, 50);
`endif
    pulse_start(5);
    pulse_halt(12);
    pulse_kick(20);
    pulse_kick(30);
    step_to(39); bus.kick = 1'b1; bus.start = 1'b1;
    step_to(40); bus.kick = 1'b0; bus.start = 1'b0;
    pulse_kick(50);
    pulse_kick(60);
    pulse_halt(66);
    pulse_start(80);
`ifdef RUN_CTRL_WATCHDOG_EN
    step_to(121);
`else
    step_to(147);
`endif
    drain(20);

    // Early halt.
    do_reset();
    expect_at(29, "halt_pre",      4'b0000, 1, 0, 0, 13);
    expect_at(30, "halt_done",     4'b0000, 0, 1, 0, 14);
    expect_at(33, "halt_frozen",   4'b0000, 0, 1, 0, 14);
    pulse_halt(30);
    step_to(34);
    drain(20);

    // Halt on the edge a watchdog without kicks would expire.
    do_reset();
    expect_at(35, "hw_pre",        4'b0000, 1, 0, 0, 19);
    expect_at(36, "halt_vs_wdt",   4'b0000, 0, 1, 0, 20);
    expect_at(38, "hw_sticky",     4'b0000, 0, 1, 0, 20);
    pulse_halt(36);
    step_to(39);
    drain(20);

    // Asynchronous reset in the middle of RUN.
    do_reset();
    expect_at(39, "pre_async",     4'b0000, 1, 0, 0, 23);
    pulse_kick(30);
    step_to(39);
    @(posedge clk);
    #1 rst = 1'b1;
    phase++;
    expect_at(0,  "async_reset",   4'b1111, 0, 0, 0, 0);
    expect_at(10, "after_async",   4'b1110, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;
    step_to(11);
    drain(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
